// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers, element/state typedefs and the MixColumns FSM state enum.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [7:0]        byte_t;
  typedef logic [3:0][7:0]   column_t;
  typedef logic [15:0][7:0]  state_t;  // index 15 holds byte 0 (MSB of the bus)

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} fsm_state_t;

  localparam logic [3:0] INV_C0 = 4'hE;
  localparam logic [3:0] INV_C1 = 4'hB;
  localparam logic [3:0] INV_C2 = 4'hD;
  localparam logic [3:0] INV_C3 = 4'h9;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_gf_mul.sv
// One InvMixColumns output byte: rotates the column by row and applies the 0E/0B/0D/09 products.
// With MIXCOL_FWD_EN defined, mode=1 switches to the forward 02/03/01/01 coefficients.
module inv_gf_mul
  import aes_pkg::*;
(
  input  logic [7:0] index0,
  input  logic [7:0] index1,
  input  logic [7:0] index2,
  input  logic [7:0] index3,
  input  logic [1:0] row,
`ifdef MIXCOL_FWD_EN
  input  logic       mode,
`endif
  output logic [7:0] result
);

  column_t rot;

  // Constant-coefficient multiply; the xtime chain collapses to fixed XOR trees.
  function automatic byte_t gmul(input byte_t a, input logic [3:0] c);
    byte_t p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  always_comb begin
    rot = {index0, index1, index2, index3};
    case (row)
      2'd0: rot = {index0, index1, index2, index3};
      2'd1: rot = {index1, index2, index3, index0};
      2'd2: rot = {index2, index3, index0, index1};
      2'd3: rot = {index3, index0, index1, index2};
      default: rot = {index0, index1, index2, index3};
    endcase
  end

  // rot[3] is the row's own byte, rot[0] the one three rows down.
  byte_t inv_res;
  assign inv_res = gmul(rot[3], INV_C0) ^ gmul(rot[2], INV_C1) ^
                   gmul(rot[1], INV_C2) ^ gmul(rot[0], INV_C3);

`ifdef MIXCOL_FWD_EN
  byte_t fwd_res;
  assign fwd_res = xtime(rot[3]) ^ xtime(rot[2]) ^ rot[2] ^ rot[1] ^ rot[0];
  assign result  = mode ? fwd_res : inv_res;
`else
  assign result  = inv_res;
`endif

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: one output byte per COMPUTE cycle through a shared row multiplier.
// Optional MIXCOL_FWD_EN adds a mode input selecting forward MixColumns.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int STATE_W = 128,
  parameter int BYTE_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
`ifdef MIXCOL_FWD_EN
  input  logic               mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);

  fsm_state_t        fsm;
  state_t            state_q;
  state_t            out_q;
  logic [1:0]        row_q;
  logic [1:0]        col_q;
  logic              last_q;
  logic [BYTE_W-1:0] mul_result;
`ifdef MIXCOL_FWD_EN
  logic              mode_q;
`endif

  inv_gf_mul u_mul (
    .index0 (state_q[~{col_q, 2'd0}]),
    .index1 (state_q[~{col_q, 2'd1}]),
    .index2 (state_q[~{col_q, 2'd2}]),
    .index3 (state_q[~{col_q, 2'd3}]),
    .row    (row_q),
`ifdef MIXCOL_FWD_EN
    .mode   (mode_q),
`endif
    .result (mul_result)
  );

  assign out_data = out_q;

  // last_q marks that byte 15 has been written; DONE follows one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_q     <= '0;
      state_q   <= '0;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      last_q    <= 1'b0;
`ifdef MIXCOL_FWD_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_q  <= in_data;
            row_q    <= 2'd0;
            col_q    <= 2'd0;
            last_q   <= 1'b0;
            in_ready <= 1'b0;
            fsm      <= COMPUTE;
`ifdef MIXCOL_FWD_EN
            mode_q   <= mode;
`endif
          end
        end
        COMPUTE: begin
          if (!last_q) begin
            out_q[~{col_q, row_q}] <= mul_result;
            row_q <= row_q + 2'd1;
            if (row_q == 2'd3) col_q <= col_q + 2'd1;
            if (row_q == 2'd3 && col_q == 2'd3) last_q <= 1'b1;
          end else begin
            fsm       <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq with a queue scoreboard; exercises MIXCOL_FWD_EN when defined.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
`ifdef MIXCOL_FWD_EN
  logic         mode = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [127:0] sb_q[$];

  always #5 clk = ~clk;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef MIXCOL_FWD_EN
    .mode      (mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent shift-and-add GF(2^8) multiply, reduced by 0x11B.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input bit fwd);
    logic [127:0] r;
    logic [7:0] a[4];
    logic [7:0] k[4];
    r = '0;
    if (fwd) k = '{8'h02, 8'h03, 8'h01, 8'h01};
    else     k = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = d[127 - 8*(4*c + i) -: 8];
      for (int rr = 0; rr < 4; rr++)
        r[127 - 8*(4*c + rr) -: 8] = gm(a[rr], k[0]) ^ gm(a[(rr+1)%4], k[1]) ^
                                      gm(a[(rr+2)%4], k[2]) ^ gm(a[(rr+3)%4], k[3]);
    end
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_wait", {127'b0, in_ready}, 128'd1);
  endtask

  // Drive one state, verify latency/in_ready gating, optional back-pressure, then scoreboard compare.
  task automatic run_op(input logic [127:0] d, input logic [127:0] exp, input bit fwd,
                        input int hold, input bit inject);
    int cnt;
    logic [127:0] held;
    wait_ready();
    out_ready = (hold == 0);
    in_data   = d;
    in_valid  = 1'b1;
`ifdef MIXCOL_FWD_EN
    mode      = fwd;
`endif
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
`ifdef MIXCOL_FWD_EN
    mode     = ~fwd;
`endif
    cnt = 0;
    while (cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (out_valid) break;
      check("in_ready_busy", {127'b0, in_ready}, 128'd0);
      if (inject && cnt == 3) begin
        in_valid = 1'b1;
        in_data  = {128{1'b1}};
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("latency", 128'(cnt), 128'd17);
    check("in_ready_done", {127'b0, in_ready}, 128'd0);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {127'b0, out_valid}, 128'd1);
      check("hold_data", out_data, held);
    end
    if (sb_q.size() == 0) check("sb_empty", 128'd1, 128'd0);
    else check("result", out_data, sb_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after", {127'b0, in_ready}, 128'd1);
    check("valid_after", {127'b0, out_valid}, 128'd0);
  endtask

  initial begin
    logic [127:0] r;
    int seen;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {127'b0, out_valid}, 128'd0);
    check("rst_data", out_data, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {127'b0, in_ready}, 128'd1);

    // Directed vectors
    run_op(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
           128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 0, 1'b0);
    run_op(128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d,
           128'hd4d4d4d5_2d26314c_db135345_f20a225c, 1'b0, 0, 1'b1);

    // Back-pressure
    run_op(128'h8e4da1bc_8e4da1bc_8e4da1bc_8e4da1bc,
           128'hdb135345_db135345_db135345_db135345, 1'b0, 10, 1'b0);

    // Random states against the model
    for (int i = 0; i < 3; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      run_op(r, model(r, 1'b0), 1'b0, i, 1'b0);
    end

    // Reset mid-operation
    wait_ready();
    in_data  = 128'h0123456789abcdef_fedcba9876543210;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_data", out_data, 128'd0);
    check("midrst_ready", {127'b0, in_ready}, 128'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_valid", 128'(seen), 128'd0);
    run_op({4{32'h01010101}}, {4{32'h01010101}}, 1'b0, 0, 1'b0);

`ifdef MIXCOL_FWD_EN
    run_op({4{32'hdb135345}}, {4{32'h8e4da1bc}}, 1'b1, 0, 1'b0);
    r = {$urandom, $urandom, $urandom, $urandom};
    run_op(r, model(r, 1'b1), 1'b1, 2, 1'b0);
    run_op({4{32'h8e4da1bc}}, {4{32'hdb135345}}, 1'b0, 0, 1'b0);
`endif

    check("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
